// File: rtl/dcim_shift_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcim_shift_acc_ctrl
// Brief    : Bit-serial shift-accumulate sequencer feeding the DCIM CLA,
//            MSB-first, with optional negative-weight MSB plane.
// Revision : 1.0 - initial release
// ============================================================================
module dcim_shift_acc_ctrl #(
    parameter int ACC_W   = 24,
    parameter int PSUM_W  = 16,
    parameter int IN_BITS = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_nbits,
    input  logic              cfg_signed,
    output logic [CNT_W-1:0]  bit_idx,
    input  logic [PSUM_W-1:0] psum,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_max_nb = CNT_W'(IN_BITS);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_sgn;
    logic             r_first;

    logic [CNT_W-1:0] w_nb;
    logic             w_xfer;
    logic             w_neg;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_a;
    logic [ACC_W-1:0] w_b;
    logic [ACC_W-1:0] w_sum;
    logic             w_shift_ovf;
    logic             w_add_ovf;

    assign w_nb   = ((cfg_nbits == '0) || (cfg_nbits > c_max_nb)) ? c_max_nb : cfg_nbits;
    assign w_xfer = psum_valid && psum_ready;

    // The first (MSB) plane carries negative weight in signed mode: a + ~e + 1.
    assign w_neg  = r_first && r_sgn;
    assign w_ext  = ACC_W'($signed(psum));
    assign w_a    = {r_acc[ACC_W-2:0], 1'b0};
    assign w_b    = w_neg ? ~w_ext : w_ext;
    assign w_sum  = w_a + w_b + {{(ACC_W-1){1'b0}}, w_neg};

    assign w_shift_ovf = r_acc[ACC_W-1] != r_acc[ACC_W-2];
    assign w_add_ovf   = (w_a[ACC_W-1] == w_b[ACC_W-1]) && (w_sum[ACC_W-1] != w_a[ACC_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_sgn      <= 1'b0;
            r_first    <= 1'b0;
            bit_idx    <= '0;
            psum_ready <= 1'b0;
            acc_out    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sgn      <= cfg_signed;
                        r_acc      <= '0;
                        ovf        <= 1'b0;
                        bit_idx    <= w_nb - CNT_W'(1);
                        r_first    <= 1'b1;
                        psum_ready <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc   <= w_sum;
                        r_first <= 1'b0;
                        if (w_shift_ovf || w_add_ovf) begin
                            ovf <= 1'b1;
                        end
                        if (bit_idx == '0) begin
                            acc_out    <= w_sum;
                            out_valid  <= 1'b1;
                            psum_ready <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            bit_idx <= bit_idx - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcim_shift_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcim_shift_acc_ctrl
// Brief    : Directed and randomized checks against an integer shift-add model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcim_shift_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_nbits;
    logic        cfg_signed;
    logic [3:0]  bit_idx;
    logic [15:0] psum;
    logic        psum_valid;
    logic        psum_ready;
    logic [23:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        ovf;

    logic        start16;
    logic [3:0]  cfg_nbits16;
    logic        cfg_signed16;
    logic [3:0]  bit_idx16;
    logic [15:0] psum16;
    logic        psum_valid16;
    logic        psum_ready16;
    logic [15:0] acc_out16;
    logic        out_valid16;
    logic        out_ready16;
    logic        busy16;
    logic        ovf16;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] ps [0:7];
    logic [23:0] last_acc;
    logic        last_ovf;

    always #5 clk = ~clk;

    dcim_shift_acc_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_nbits(cfg_nbits),
        .cfg_signed(cfg_signed), .bit_idx(bit_idx), .psum(psum),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .ovf(ovf)
    );

    dcim_shift_acc_ctrl #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .cfg_nbits(cfg_nbits16),
        .cfg_signed(cfg_signed16), .bit_idx(bit_idx16), .psum(psum16),
        .psum_valid(psum_valid16), .psum_ready(psum_ready16), .acc_out(acc_out16),
        .out_valid(out_valid16), .out_ready(out_ready16), .busy(busy16), .ovf(ovf16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, wrapped to 24 bits after each plane.
    function automatic void model(input int nb_cfg, input bit sgn, output int nb,
                                  output logic [23:0] res, output bit ov);
        longint acc, two, s, e;
        nb  = (nb_cfg == 0 || nb_cfg > 8) ? 8 : nb_cfg;
        acc = 0;
        ov  = 1'b0;
        for (int k = 0; k < nb; k++) begin
            e   = longint'($signed(ps[k]));
            two = acc * 2;
            if (two > 64'sd8388607 || two < -64'sd8388608) ov = 1'b1;
            s = (k == 0 && sgn) ? two - e : two + e;
            if (s > 64'sd8388607 || s < -64'sd8388608) ov = 1'b1;
            acc = s & 64'hFF_FFFF;
            if (acc >= 64'sd8388608) acc = acc - 64'sd16777216;
        end
        res = 24'(acc);
    endfunction

    task automatic run_op(input int nb_cfg, input bit sgn, input int valid_pct,
                          input int hold, input bit noise);
        int          nb;
        logic [23:0] exp_res;
        bit          exp_ov;
        bit          v;
        int          guard;
        model(nb_cfg, sgn, nb, exp_res, exp_ov);
        out_ready  = (hold == 0);
        start      = 1'b1;
        cfg_nbits  = 4'(nb_cfg);
        cfg_signed = sgn;
        step();
        start = 1'b0;
        check("start_ready", {63'd0, psum_ready}, 64'd1);
        check("start_busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < nb; k++) begin
            guard = 0;
            do begin
                psum       = ps[k];
                v          = ($urandom_range(0, 99) < valid_pct);
                psum_valid = v;
                if (noise) begin
                    start     = 1'($urandom_range(0, 1));
                    cfg_nbits = 4'($urandom_range(0, 15));
                end
                if (v) begin
                    check("bit_idx", {60'd0, bit_idx}, 64'(nb - 1 - k));
                    check("accum_ready", {63'd0, psum_ready}, 64'd1);
                end
                step();
                guard++;
            end while (!v && guard < 200);
            if (!v) check("xfer_timeout", 64'd0, 64'd1);
        end
        psum_valid = 1'b0;
        start      = 1'b0;
        check("out_valid_rise", {63'd0, out_valid}, 64'd1);
        check("acc_out", {40'd0, acc_out}, {40'd0, exp_res});
        check("ovf", {63'd0, ovf}, {63'd0, exp_ov});
        check("done_ready", {63'd0, psum_ready}, 64'd0);
        last_acc = acc_out;
        last_ovf = ovf;
        for (int h = 0; h < hold; h++) begin
            if (noise) start = 1'($urandom_range(0, 1));
            step();
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_acc", {40'd0, acc_out}, {40'd0, exp_res});
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        check("out_valid_fall", {63'd0, out_valid}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b1; cfg_nbits = 4'd5; cfg_signed = 1'b1;
        psum = 16'h1234; psum_valid = 1'b1; out_ready = 1'b0;
        start16 = 1'b0; cfg_nbits16 = 4'd0; cfg_signed16 = 1'b0;
        psum16 = 16'd0; psum_valid16 = 1'b0; out_ready16 = 1'b0;
        step(); step(); step();
        check("rst_bit_idx", {60'd0, bit_idx}, 64'd0);
        check("rst_ready", {63'd0, psum_ready}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_acc", {40'd0, acc_out}, 64'd0);
        start = 1'b0; psum_valid = 1'b0; rst = 1'b0;
        step();
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        ps[0] = 16'd3; ps[1] = 16'd0; ps[2] = 16'd1; ps[3] = 16'd2;
        run_op(4, 1'b0, 100, 0, 1'b0);
        check("u4_const", {40'd0, last_acc}, 64'h1C);
        check("u4_ovf", {63'd0, last_ovf}, 64'd0);
        run_op(4, 1'b1, 100, 0, 1'b0);
        check("s4_const", {40'd0, last_acc}, 64'hFFFFEC);

        ps[0] = 16'hFFFB;
        run_op(1, 1'b0, 100, 0, 1'b0);
        check("u1_const", {40'd0, last_acc}, 64'hFFFFFB);
        run_op(1, 1'b1, 100, 0, 1'b0);
        check("s1_const", {40'd0, last_acc}, 64'h000005);

        // Narrow instance: 0x4000 shifted into the sign bit flags overflow.
        start16 = 1'b1; cfg_nbits16 = 4'd2; cfg_signed16 = 1'b0;
        step();
        start16 = 1'b0; psum16 = 16'h4000; psum_valid16 = 1'b1;
        step();
        psum16 = 16'h0001;
        step();
        psum_valid16 = 1'b0;
        check("w16_valid", {63'd0, out_valid16}, 64'd1);
        check("w16_acc", {48'd0, acc_out16}, 64'h8001);
        check("w16_ovf", {63'd0, ovf16}, 64'd1);
        out_ready16 = 1'b1;
        step();
        check("w16_fall", {63'd0, out_valid16}, 64'd0);
        start16 = 1'b1; cfg_nbits16 = 4'd1;
        step();
        start16 = 1'b0;
        check("w16_ovf_clr", {63'd0, ovf16}, 64'd0);
        psum16 = 16'h0001; psum_valid16 = 1'b1;
        step();
        psum_valid16 = 1'b0;
        check("w16_acc2", {48'd0, acc_out16}, 64'h0001);

        for (int k = 0; k < 8; k++) ps[k] = 16'($urandom);
        run_op(0, 1'b0, 100, 0, 1'b0);
        for (int k = 0; k < 8; k++) ps[k] = 16'($urandom);
        run_op(12, 1'b1, 100, 0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++)
                ps[k] = (n % 2 == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
            run_op((n == 0) ? 8 : int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   50, (n == 0) ? 5 : int'($urandom_range(0, 4)), 1'b1);
        end

        // Reset in the middle of an accumulation discards it.
        start = 1'b1; cfg_nbits = 4'd8; cfg_signed = 1'b0;
        step();
        start = 1'b0; psum = 16'd7; psum_valid = 1'b1;
        step(); step();
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_ready", {63'd0, psum_ready}, 64'd0);
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        psum_valid = 1'b0;
        check("midrst_no_valid", {63'd0, seen}, 64'd0);
        check("midrst_idle", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
